// File: rtl/ram_multiread_sdp.sv
// ram_multiread_sdp: simple dual-port RAM with one byte-strobed write port and
// NUM_RPORTS independent registered read ports, each with its own valid pipeline.
// A built-in sequencer zeroes the whole array after reset and on request.
module ram_multiread_sdp #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 64,
    parameter int BYTE_WIDTH   = 8,
    parameter int NUM_RPORTS   = 2,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_FIRST  = 0
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               en,
    input  logic [ADDR_WIDTH-1:0]              waddr,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   strobe,
    input  logic [DATA_WIDTH-1:0]              wdata,
    input  logic [NUM_RPORTS-1:0]              ren,
    input  logic [NUM_RPORTS*ADDR_WIDTH-1:0]   raddr,
    output logic [NUM_RPORTS*DATA_WIDTH-1:0]   rdata,
    output logic [NUM_RPORTS-1:0]              rvalid,
    input  logic                               clear,
    output logic                               busy
);

    localparam int DEPTH     = 1 << ADDR_WIDTH;
    localparam int NUM_LANES = DATA_WIDTH / BYTE_WIDTH;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;

    logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];

    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [NUM_LANES-1:0]    wr_mask;
    logic [DATA_WIDTH-1:0]   wr_data;

    logic [NUM_RPORTS-1:0]   rd_accept;
    logic [ADDR_WIDTH-1:0]   rd_addr [NUM_RPORTS];
    logic [DATA_WIDTH-1:0]   rd_old  [NUM_RPORTS];
    logic [DATA_WIDTH-1:0]   rd_word [NUM_RPORTS];

    logic                    vld_q [NUM_RPORTS][READ_LATENCY];
    logic                    vld_d [NUM_RPORTS][READ_LATENCY];
    logic [DATA_WIDTH-1:0]   dat_q [NUM_RPORTS][READ_LATENCY];
    logic [DATA_WIDTH-1:0]   dat_d [NUM_RPORTS][READ_LATENCY];

    assign busy = (state_q == ST_CLEAR);

    // Clear sequencer: sweep every word once, then serve traffic until a clear request.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                if (ptr_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = ST_READY;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + ADDR_WIDTH'(1);
                end
            end
            ST_READY: begin
                if (clear) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    // Sequencer state register; reset restarts the sweep from address 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Write port mux: the sweep owns the array while clearing, the user port otherwise.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = waddr;
        wr_mask = strobe;
        wr_data = wdata;
        if (busy) begin
            wr_en   = 1'b1;
            wr_addr = ptr_q;
            wr_mask = '1;
            wr_data = '0;
        end else begin
            wr_en = en;
        end
    end

    // Storage array, written lane by lane so unstrobed bytes keep their contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (wr_mask[l]) begin
                    mem[wr_addr][l*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[l*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // First read stage: fetch the addressed word and apply write-first merging on collision.
    always_comb begin
        for (int p = 0; p < NUM_RPORTS; p++) begin
            rd_accept[p] = ren[p] & ~busy;
            rd_addr[p]   = raddr[p*ADDR_WIDTH +: ADDR_WIDTH];
            rd_old[p]    = mem[rd_addr[p]];
            rd_word[p]   = rd_old[p];
            if ((WRITE_FIRST != 0) && en && (waddr == rd_addr[p])) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    if (strobe[l]) begin
                        rd_word[p][l*BYTE_WIDTH +: BYTE_WIDTH] = wdata[l*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
            end
        end
    end

    // Read pipeline: stage data only moves with a valid, so the output holds its last value.
    always_comb begin
        for (int p = 0; p < NUM_RPORTS; p++) begin
            for (int s = 0; s < READ_LATENCY; s++) begin
                vld_d[p][s] = 1'b0;
                dat_d[p][s] = dat_q[p][s];
                if (s == 0) begin
                    vld_d[p][s] = rd_accept[p];
                    if (rd_accept[p]) begin
                        dat_d[p][s] = rd_word[p];
                    end
                end else begin
                    vld_d[p][s] = vld_q[p][s-1];
                    if (vld_q[p][s-1]) begin
                        dat_d[p][s] = dat_q[p][s-1];
                    end
                end
            end
        end
    end

    // Read pipeline registers; everything invalid and zeroed on reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int p = 0; p < NUM_RPORTS; p++) begin
                for (int s = 0; s < READ_LATENCY; s++) begin
                    vld_q[p][s] <= 1'b0;
                    dat_q[p][s] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < NUM_RPORTS; p++) begin
                for (int s = 0; s < READ_LATENCY; s++) begin
                    vld_q[p][s] <= vld_d[p][s];
                    dat_q[p][s] <= dat_d[p][s];
                end
            end
        end
    end

    // Last pipeline stage drives the packed output ports.
    always_comb begin
        for (int p = 0; p < NUM_RPORTS; p++) begin
            rvalid[p]                          = vld_q[p][READ_LATENCY-1];
            rdata[p*DATA_WIDTH +: DATA_WIDTH]  = dat_q[p][READ_LATENCY-1];
        end
    end

endmodule

// File: tb/tb_ram_multiread_sdp.sv
// Testbench for ram_multiread_sdp: two instances share all inputs, one read-first with
// single-cycle latency, one write-first with three-cycle latency.
module tb_ram_multiread_sdp;

    localparam int AW = 10;
    localparam int DW = 64;
    localparam int NP = 2;
    localparam int NL = 8;

    logic             clk = 1'b0;
    logic             resetn;
    logic             en;
    logic [AW-1:0]    waddr;
    logic [NL-1:0]    strobe;
    logic [DW-1:0]    wdata;
    logic [NP-1:0]    ren;
    logic [NP*AW-1:0] raddr;
    logic             clear;

    logic [NP*DW-1:0] rdata_a, rdata_b;
    logic [NP-1:0]    rvalid_a, rvalid_b;
    logic             busy_a, busy_b;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic          en;
        logic [AW-1:0] waddr;
        logic [7:0]    strobe;
        logic [63:0]   wdata;
        logic [1:0]    ren;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [63:0]   exp0_a;
        logic [63:0]   exp0_b;
        logic [63:0]   exp1_a;
        logic [63:0]   exp1_b;
    } vec_t;

    vec_t vecs [13];

    always #5 clk = ~clk;

    ram_multiread_sdp #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8),
        .NUM_RPORTS(NP), .READ_LATENCY(1), .WRITE_FIRST(0)
    ) dut_a (
        .clk(clk), .resetn(resetn), .en(en), .waddr(waddr), .strobe(strobe),
        .wdata(wdata), .ren(ren), .raddr(raddr), .rdata(rdata_a),
        .rvalid(rvalid_a), .clear(clear), .busy(busy_a)
    );

    ram_multiread_sdp #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8),
        .NUM_RPORTS(NP), .READ_LATENCY(3), .WRITE_FIRST(1)
    ) dut_b (
        .clk(clk), .resetn(resetn), .en(en), .waddr(waddr), .strobe(strobe),
        .wdata(wdata), .ren(ren), .raddr(raddr), .rdata(rdata_b),
        .rvalid(rvalid_b), .clear(clear), .busy(busy_b)
    );

    function automatic vec_t mk(input logic e, input logic [AW-1:0] wa, input logic [7:0] st,
                                input logic [63:0] wd, input logic [1:0] r,
                                input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                input logic [63:0] e0a, input logic [63:0] e0b,
                                input logic [63:0] e1a, input logic [63:0] e1b);
        vec_t v;
        v.en = e; v.waddr = wa; v.strobe = st; v.wdata = wd; v.ren = r;
        v.ra0 = a0; v.ra1 = a1;
        v.exp0_a = e0a; v.exp0_b = e0b; v.exp1_a = e1a; v.exp1_b = e1b;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One-cycle transaction: inputs driven at negedge, returned to idle 1ns after the edge.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        en     = v.en;
        waddr  = v.waddr;
        strobe = v.strobe;
        wdata  = v.wdata;
        ren    = v.ren;
        raddr  = {v.ra1, v.ra0};
        @(posedge clk);
        #1;
        en  = 1'b0;
        ren = '0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        applyStimulus(v);
        checkOutput({tag, " rvalid_a"}, 64'(rvalid_a), 64'(v.ren));
        if (v.ren[0]) checkOutput({tag, " rdata_a p0"}, rdata_a[63:0], v.exp0_a);
        if (v.ren[1]) checkOutput({tag, " rdata_a p1"}, rdata_a[127:64], v.exp1_a);
        repeat (2) @(posedge clk);
        #1;
        checkOutput({tag, " rvalid_a pulse"}, 64'(rvalid_a), 64'd0);
        checkOutput({tag, " rvalid_b"}, 64'(rvalid_b), 64'(v.ren));
        if (v.ren[0]) checkOutput({tag, " rdata_b p0"}, rdata_b[63:0], v.exp0_b);
        if (v.ren[1]) checkOutput({tag, " rdata_b p1"}, rdata_b[127:64], v.exp1_b);
    endtask

    task automatic read_both(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                             input logic [63:0] e0, input logic [63:0] e1, input string tag);
        run_vec(mk(1'b0, '0, 8'h00, 64'd0, 2'b11, a0, a1, e0, e0, e1, e1), tag);
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [63:0] d);
        run_vec(mk(1'b1, a, 8'hFF, d, 2'b00, '0, '0, 64'd0, 64'd0, 64'd0, 64'd0), "write");
    endtask

    // Counts edges until busy drops, bounded so a stuck sequencer still reaches the summary.
    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (busy_a && cnt < 3000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
    endtask

    logic [63:0] vals [4];
    int          cnt;
    int          spurious;

    initial begin
        resetn = 1'b0; en = 1'b0; waddr = '0; strobe = '0; wdata = '0;
        ren = '0; raddr = '0; clear = 1'b0;

        vecs[0]  = mk(1'b0, 10'd0,    8'h00, 64'd0, 2'b11, 10'd0, 10'd1023,
                      64'd0, 64'd0, 64'd0, 64'd0);
        vecs[1]  = mk(1'b1, 10'd5,    8'hFF, 64'h1122334455667788, 2'b00, 10'd0, 10'd0,
                      64'd0, 64'd0, 64'd0, 64'd0);
        vecs[2]  = mk(1'b1, 10'd5,    8'h0F, 64'hAAAAAAAAAAAAAAAA, 2'b00, 10'd0, 10'd0,
                      64'd0, 64'd0, 64'd0, 64'd0);
        vecs[3]  = mk(1'b0, 10'd0,    8'h00, 64'd0, 2'b11, 10'd5, 10'd5,
                      64'h11223344AAAAAAAA, 64'h11223344AAAAAAAA,
                      64'h11223344AAAAAAAA, 64'h11223344AAAAAAAA);
        vecs[4]  = mk(1'b1, 10'd7,    8'h01, 64'hFF, 2'b11, 10'd7, 10'd5,
                      64'h0, 64'hFF, 64'h11223344AAAAAAAA, 64'h11223344AAAAAAAA);
        vecs[5]  = mk(1'b0, 10'd0,    8'h00, 64'd0, 2'b11, 10'd7, 10'd7,
                      64'hFF, 64'hFF, 64'hFF, 64'hFF);
        vecs[6]  = mk(1'b1, 10'd7,    8'h00, 64'hFFFFFFFFFFFFFFFF, 2'b10, 10'd0, 10'd7,
                      64'd0, 64'd0, 64'hFF, 64'hFF);
        vecs[7]  = mk(1'b0, 10'd0,    8'h00, 64'd0, 2'b01, 10'd7, 10'd0,
                      64'hFF, 64'hFF, 64'd0, 64'd0);
        vecs[8]  = mk(1'b1, 10'd9,    8'h81, 64'hDEADBEEFCAFEF00D, 2'b10, 10'd0, 10'd9,
                      64'd0, 64'd0, 64'h0, 64'hDE0000000000000D);
        vecs[9]  = mk(1'b0, 10'd0,    8'h00, 64'd0, 2'b11, 10'd9, 10'd5,
                      64'hDE0000000000000D, 64'hDE0000000000000D,
                      64'h11223344AAAAAAAA, 64'h11223344AAAAAAAA);
        vecs[10] = mk(1'b1, 10'd1023, 8'hF0, 64'h0123456789ABCDEF, 2'b00, 10'd0, 10'd0,
                      64'd0, 64'd0, 64'd0, 64'd0);
        vecs[11] = mk(1'b1, 10'd0,    8'hFF, 64'h5555555555555555, 2'b11, 10'd0, 10'd1023,
                      64'h0, 64'h5555555555555555, 64'h0123456700000000, 64'h0123456700000000);
        vecs[12] = mk(1'b0, 10'd0,    8'h00, 64'd0, 2'b01, 10'd0, 10'd0,
                      64'h5555555555555555, 64'h5555555555555555, 64'd0, 64'd0);

        // Reset state and initial sweep length.
        #23;
        checkOutput("reset rvalid_a", 64'(rvalid_a), 64'd0);
        checkOutput("reset rvalid_b", 64'(rvalid_b), 64'd0);
        checkOutput("reset rdata_a", rdata_a[63:0] | rdata_a[127:64], 64'd0);
        checkOutput("reset busy_a", 64'(busy_a), 64'd1);
        @(negedge clk);
        resetn = 1'b1;
        wait_ready(cnt);
        checkOutput("reset sweep cycles", 64'(cnt), 64'd1024);
        checkOutput("reset sweep busy_b", 64'(busy_b), 64'd0);

        // Directed vector table.
        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back pipelined reads, with a write to an address already in flight.
        vals[0] = 64'd0;
        vals[1] = 64'h1111111111111111;
        vals[2] = 64'h2222222222222222;
        vals[3] = 64'h3333333333333333;
        for (int a = 1; a < 4; a++) write_word(AW'(a), vals[a]);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            ren    = (k < 3) ? 2'b11 : 2'b00;
            raddr  = {AW'(3 - k), AW'(k + 1)};
            en     = (k == 2);
            waddr  = 10'd2;
            strobe = 8'hFF;
            wdata  = 64'h9999999999999999;
            @(posedge clk);
            #1;
            checkOutput($sformatf("pipe%0d rvalid_a", k), 64'(rvalid_a), (k < 3) ? 64'd3 : 64'd0);
            if (k < 3) begin
                checkOutput($sformatf("pipe%0d rdata_a p0", k), rdata_a[63:0], vals[k+1]);
                checkOutput($sformatf("pipe%0d rdata_a p1", k), rdata_a[127:64], vals[3-k]);
            end
            checkOutput($sformatf("pipe%0d rvalid_b", k), 64'(rvalid_b),
                        (k >= 2 && k <= 4) ? 64'd3 : 64'd0);
            if (k >= 2) begin
                checkOutput($sformatf("pipe%0d rdata_b p0", k), rdata_b[63:0], vals[(k > 4 ? 2 : k-2) + 1]);
                checkOutput($sformatf("pipe%0d rdata_b p1", k), rdata_b[127:64], vals[3 - (k > 4 ? 2 : k-2)]);
            end
        end
        en  = 1'b0;
        ren = '0;
        read_both(10'd2, 10'd1, 64'h9999999999999999, vals[1], "after pipe");

        // Clear request while a read is in flight in the deeper pipeline.
        for (int a = 0; a < 16; a++) write_word(AW'(a), 64'hC0DE000000000000 | 64'(a));
        @(negedge clk);
        ren   = 2'b01;
        raddr = {10'd0, 10'd4};
        @(posedge clk);
        #1;
        ren   = '0;
        clear = 1'b1;
        checkOutput("clr inflight rdata_a", rdata_a[63:0], 64'hC0DE000000000004);
        @(posedge clk);
        #1;
        clear  = 1'b0;
        checkOutput("clr busy_a", 64'(busy_a), 64'd1);
        checkOutput("clr busy_b", 64'(busy_b), 64'd1);
        checkOutput("clr rvalid_b early", 64'(rvalid_b), 64'd0);
        ren    = 2'b11;
        raddr  = {10'd4, 10'd4};
        en     = 1'b1;
        waddr  = 10'd4;
        strobe = 8'hFF;
        wdata  = 64'hFFFFFFFFFFFFFFFF;
        cnt = 0;
        spurious = 0;
        while (busy_a && cnt < 3000) begin
            @(posedge clk);
            #1;
            cnt++;
            if (cnt == 1) begin
                checkOutput("clr inflight rvalid_b", 64'(rvalid_b), 64'd1);
                checkOutput("clr inflight rdata_b", rdata_b[63:0], 64'hC0DE000000000004);
                if (rvalid_a != 0) spurious++;
            end else if (rvalid_a != 0 || rvalid_b != 0) begin
                spurious++;
            end
        end
        en  = 1'b0;
        ren = '0;
        checkOutput("clr sweep cycles", 64'(cnt), 64'd1024);
        checkOutput("clr ignored reads", 64'(spurious), 64'd0);
        for (int a = 0; a < 16; a += 2) begin
            read_both(AW'(a), AW'(a + 1), 64'd0, 64'd0, $sformatf("clr zero%0d", a));
        end

        // Reset asserted halfway through a sweep restarts it from address 0.
        write_word(10'd1000, 64'hABCDABCDABCDABCD);
        write_word(10'd20, 64'h1234123412341234);
        read_both(10'd20, 10'd1000, 64'h1234123412341234, 64'hABCDABCDABCDABCD, "pre rst");
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        repeat (500) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        checkOutput("midrst rvalid_a", 64'(rvalid_a), 64'd0);
        checkOutput("midrst rdata_a", rdata_a[63:0] | rdata_a[127:64], 64'd0);
        checkOutput("midrst rdata_b", rdata_b[63:0] | rdata_b[127:64], 64'd0);
        checkOutput("midrst busy_a", 64'(busy_a), 64'd1);
        @(negedge clk);
        resetn = 1'b1;
        wait_ready(cnt);
        checkOutput("midrst sweep cycles", 64'(cnt), 64'd1024);
        read_both(10'd20, 10'd1000, 64'd0, 64'd0, "post rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
